vp_psum_accumulator: RTL and testbench

- Consumer stage directly downstream of the VP encoder.
- Captures each completed 3-entry right or left ping-pong buffer (weight, activation, address), multiplies each weight/activation pair, and accumulates the product into an on-chip partial-sum register file indexed by address.
- Signals completion once the encoder's finish has been seen and all captured work has retired.
- Exposes a read port for draining partial sums.

---
 rtl/vp_psum_accumulator.sv | 208 ++++++++++++++++++++
 tb/tb_vp_psum_accumulator.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vp_psum_accumulator.sv
// Partial-sum accumulator behind the VP encoder: captures right/left ping-pong buffers,
// multiplies each weight/activation pair and accumulates into an address-indexed register file.
module vp_psum_accumulator #(
  parameter  int PSUM_DEPTH = 128,
  parameter  int ACC_W      = 40,
  localparam int IDX_W      = $clog2(PSUM_DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_right_ready,
  input  logic                    i_left_ready,
  input  logic                    i_finish,
  input  logic [2:0][20:0]        i_addr_right,
  input  logic [2:0][15:0]        i_w_right,
  input  logic [2:0][15:0]        i_ia_right,
  input  logic [2:0][20:0]        i_addr_left,
  input  logic [2:0][15:0]        i_w_left,
  input  logic [2:0][15:0]        i_ia_left,
  input  logic                    i_rd_en,
  input  logic [IDX_W-1:0]        i_rd_addr,
  output logic signed [ACC_W-1:0] o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DRAIN} state_t;

  typedef struct packed {
    logic [IDX_W-1:0]    idx;
    logic signed [15:0]  w;
    logic signed [15:0]  ia;
  } entry_t;

  typedef entry_t [2:0] slot_t;

  function automatic slot_t pack_slot(input logic [2:0][20:0] addr,
                                      input logic [2:0][15:0] w,
                                      input logic [2:0][15:0] ia);
    slot_t s;
    for (int i = 0; i < 3; i++) begin
      s[i] = '{idx: addr[i][IDX_W-1:0], w: w[i], ia: ia[i]};
    end
    return s;
  endfunction

  state_t                  state;
  logic [1:0]              ptr;
  logic                    cur_left;
  slot_t                   slot_r, slot_l;
  logic                    pend_r, pend_l, l_first, fin_seen;
  logic                    right_q, left_q, finish_q;

  logic                    s1_v;
  logic [IDX_W-1:0]        s1_idx;
  logic signed [31:0]      s1_prod;

  logic [PSUM_DEPTH-1:0]   valid_map;
  logic signed [ACC_W-1:0] psum [PSUM_DEPTH];

  logic                    rise_r, rise_l, rise_f;
  logic                    cap_r, cap_l, retire, stay_r, stay_l;
  logic                    pend_r_n, pend_l_n, any_pend_n, l_first_n, sel_left_n;
  logic                    drain_ok, done_go, issue_hit;
  entry_t                  cur_entry;
  logic signed [ACC_W-1:0] acc_base, acc_sum;

  // Only the low index bits of each address select a psum entry.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr_right[0][20:IDX_W], i_addr_right[1][20:IDX_W],
                              i_addr_right[2][20:IDX_W], i_addr_left[0][20:IDX_W],
                              i_addr_left[1][20:IDX_W],  i_addr_left[2][20:IDX_W]};

  // NOTE: combinational blocks use blocking '='; every always_ff uses non-blocking '<='.
  always_comb begin
    // NOTE: defaults assigned first keep this block free of inferred latches.
    l_first_n  = l_first;
    rise_r     = i_right_ready & ~right_q;
    rise_l     = i_left_ready & ~left_q;
    rise_f     = i_finish & ~finish_q;
    cap_r      = rise_r & ~pend_r;
    cap_l      = rise_l & ~pend_l;
    retire     = (state == S_ISSUE) && (ptr == 2'd2);
    stay_r     = pend_r & ~(retire & ~cur_left);
    stay_l     = pend_l & ~(retire & cur_left);
    pend_r_n   = stay_r | cap_r;
    pend_l_n   = stay_l | cap_l;
    any_pend_n = pend_r_n | pend_l_n;
    // Age tracking: a newly captured slot is younger than one that stays pending.
    if (cap_r && cap_l)  l_first_n = 1'b0;
    else if (cap_l)      l_first_n = ~stay_r;
    else if (cap_r)      l_first_n = stay_l;
    sel_left_n = pend_l_n & (~pend_r_n | l_first_n);
    drain_ok   = fin_seen & ~pend_r & ~pend_l & ~s1_v;
    done_go    = (state == S_IDLE) & ~any_pend_n & drain_ok;
    cur_entry  = cur_left ? slot_l[ptr] : slot_r[ptr];
    issue_hit  = (state == S_ISSUE) && (cur_entry.w != '0) && (cur_entry.ia != '0);
    // A write coinciding with i_clear starts from zero.
    acc_base   = (valid_map[s1_idx] && !i_clear) ? psum[s1_idx] : '0;
    acc_sum    = acc_base + ACC_W'(s1_prod);
  end

  assign o_busy = pend_r | pend_l | s1_v;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      right_q   <= 1'b0;
      left_q    <= 1'b0;
      finish_q  <= 1'b0;
      pend_r    <= 1'b0;
      pend_l    <= 1'b0;
      l_first   <= 1'b0;
      fin_seen  <= 1'b0;
      o_overrun <= 1'b0;
      slot_r    <= '0;
      slot_l    <= '0;
    end else begin
      right_q  <= i_right_ready;
      left_q   <= i_left_ready;
      finish_q <= i_finish;
      pend_r   <= pend_r_n;
      pend_l   <= pend_l_n;
      l_first  <= l_first_n;
      fin_seen <= (fin_seen & ~done_go) | rise_f;
      if (cap_r) slot_r <= pack_slot(i_addr_right, i_w_right, i_ia_right);
      if (cap_l) slot_l <= pack_slot(i_addr_left, i_w_left, i_ia_left);
      if ((rise_r && pend_r) || (rise_l && pend_l)) o_overrun <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      cur_left <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (any_pend_n) begin
            state    <= S_ISSUE;
            ptr      <= '0;
            cur_left <= sel_left_n;
          end else if (drain_ok) begin
            state  <= S_WAIT_DRAIN;
            o_done <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (ptr == 2'd2) begin
            if (any_pend_n) begin
              ptr      <= '0;
              cur_left <= sel_left_n;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            ptr <= ptr + 2'd1;
          end
        end
        S_WAIT_DRAIN: begin
          if (any_pend_n) begin
            state    <= S_ISSUE;
            ptr      <= '0;
            cur_left <= sel_left_n;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_v      <= 1'b0;
      s1_idx    <= '0;
      s1_prod   <= '0;
      valid_map <= '0;
    end else begin
      s1_v    <= issue_hit;
      s1_idx  <= cur_entry.idx;
      s1_prod <= 32'($signed(cur_entry.w)) * 32'($signed(cur_entry.ia));
      if (i_clear) valid_map <= '0;
      if (s1_v) valid_map[s1_idx] <= 1'b1;
    end
  end

  // NOTE: the psum array has no reset; valid_map masks whatever it holds.
  always_ff @(posedge i_clk) begin
    if (s1_v) psum[s1_idx] <= acc_sum;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) o_rd_data <= valid_map[i_rd_addr] ? psum[i_rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_vp_psum_accumulator.sv
// Self-checking bench for vp_psum_accumulator: vector table, timed corner sequences,
// and randomized buffers against a plain-arithmetic partial-sum model.
module tb_vp_psum_accumulator;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clear, right_ready, left_ready, finish, rd_en;
  logic [2:0][20:0]    addr_r, addr_l;
  logic [2:0][15:0]    w_r, ia_r, w_l, ia_l;
  logic [6:0]          rd_addr;
  logic signed [39:0]  rd_data;
  logic                rd_valid, busy, done, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vp_psum_accumulator #(.PSUM_DEPTH(128), .ACC_W(40)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
    .i_right_ready(right_ready), .i_left_ready(left_ready), .i_finish(finish),
    .i_addr_right(addr_r), .i_w_right(w_r), .i_ia_right(ia_r),
    .i_addr_left(addr_l), .i_w_left(w_l), .i_ia_left(ia_l),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_busy(busy),
    .o_done(done), .o_overrun(overrun)
  );

  typedef struct {
    string            name;
    bit               left;
    logic [2:0][15:0] w;
    logic [2:0][15:0] ia;
    logic [2:0][20:0] addr;
    int               probe;
    longint           expected;
  } vec_t;

  vec_t vecs[$];
  logic signed [39:0] model [128];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit left, input logic [2:0][15:0] w,
                      input logic [2:0][15:0] ia, input logic [2:0][20:0] a);
    if (left) begin w_l = w; ia_l = ia; addr_l = a; end
    else      begin w_r = w; ia_r = ia; addr_r = a; end
  endtask

  task automatic load3(input bit left, input int w0, ia0, a0, w1, ia1, a1, w2, ia2, a2);
    logic [2:0][15:0] w, ia;
    logic [2:0][20:0] a;
    w[0] = 16'(w0); ia[0] = 16'(ia0); a[0] = 21'(a0);
    w[1] = 16'(w1); ia[1] = 16'(ia1); a[1] = 21'(a1);
    w[2] = 16'(w2); ia[2] = 16'(ia2); a[2] = 21'(a2);
    load(left, w, ia, a);
  endtask

  task automatic add_vec(input string name, input bit left,
                         input int w0, ia0, a0, w1, ia1, a1, w2, ia2, a2,
                         input int probe, input longint expected);
    vec_t v;
    v.name = name; v.left = left; v.probe = probe; v.expected = expected;
    v.w[0] = 16'(w0); v.ia[0] = 16'(ia0); v.addr[0] = 21'(a0);
    v.w[1] = 16'(w1); v.ia[1] = 16'(ia1); v.addr[1] = 21'(a1);
    v.w[2] = 16'(w2); v.ia[2] = 16'(ia2); v.addr[2] = 21'(a2);
    vecs.push_back(v);
  endtask

  task automatic pulse(input bit r, input bit l, input bit f);
    right_ready = r; left_ready = l; finish = f;
    tick();
    right_ready = 1'b0; left_ready = 1'b0; finish = 1'b0;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic rd_chk(input string name, input int idx, input logic signed [63:0] exp);
    rd_en = 1'b1; rd_addr = 7'(idx);
    tick();
    rd_en = 1'b0;
    check(name, rd_data, exp);
  endtask

  // exp_lat < 0: only require that the pulse shows up within max_cyc cycles.
  task automatic wait_done(input string name, input int max_cyc, input int c0, input int exp_lat);
    for (int i = 0; i < max_cyc && !done; i++) tick();
    if (!done)            check({name, "_timeout"}, 0, 1);
    else if (exp_lat >= 0) check(name, cyc - c0, exp_lat);
    else                  check(name, done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0;
    logic signed [15:0] ws, ias;
    int idx;
    longint p;

    rst_n = 1'b0; clear = 0; right_ready = 0; left_ready = 0; finish = 0;
    rd_en = 0; rd_addr = '0;
    w_r = '0; ia_r = '0; addr_r = '0; w_l = '0; ia_l = '0; addr_l = '0;
    repeat (3) tick();
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    tick();

    // Write timing: entries land at the end of t+2, t+3, t+4; done follows finish.
    load3(0, 3, 5, 7, -2, 4, 7, 1, 1, 9);
    c0 = cyc;
    pulse(1, 0, 1);
    check("lat_busy_after_capture", busy, 1);
    tick();
    rd_chk("lat_idx7_t2_prewrite", 7, 0);
    rd_chk("lat_idx7_t3", 7, 15);
    rd_chk("lat_idx7_t4", 7, 7);
    check("lat_no_done_yet", done, 0);
    rd_chk("lat_idx9_t5", 9, 1);
    check("lat_done_pulse", done, 1);
    check("lat_done_latency", cyc - c0, 6);
    check("lat_rd_valid", rd_valid, 1);
    tick();
    check("lat_done_single", done, 0);
    check("lat_rd_valid_drop", rd_valid, 0);
    check("lat_busy_idle", busy, 0);

    // Single-buffer vectors, each isolated by a clear.
    add_vec("vec_basic_r", 0, 3, 5, 7, -2, 4, 7, 1, 1, 9, 7, 7);
    add_vec("vec_basic_r_idx9", 0, 3, 5, 7, -2, 4, 7, 1, 1, 9, 9, 1);
    add_vec("vec_extremes_l", 1, -32768, -32768, 2, -32768, 32767, 2, 0, 5, 2, 2, 32768);
    add_vec("vec_all_zero_l", 1, 7, 0, 40, 0, 9, 40, 0, 0, 40, 40, 0);
    add_vec("vec_idx_modulo_r", 0, 4, 6, 135, -1, 1, 'h1FFF87, 2, 2, 7, 7, 27);
    add_vec("vec_top_idx_l", 1, 100, -100, 127, -1, -1, 127, 1, -1, 0, 127, -9999);
    foreach (vecs[i]) begin
      clear_pulse();
      load(vecs[i].left, vecs[i].w, vecs[i].ia, vecs[i].addr);
      c0 = cyc;
      pulse(!vecs[i].left, vecs[i].left, 1);
      wait_done({vecs[i].name, "_done"}, 30, c0, -1);
      rd_chk(vecs[i].name, vecs[i].probe, vecs[i].expected);
    end

    // Alternating R/L buffers 3 cycles apart must issue back to back.
    clear_pulse();
    load3(0, 1, 1, 0, 1, 1, 0, 1, 1, 0);
    load3(1, 1, 1, 0, 1, 1, 0, 1, 1, 0);
    c0 = cyc;
    pulse(1, 0, 0); tick(); tick();
    pulse(0, 1, 0); tick(); tick();
    pulse(1, 0, 0); tick(); tick();
    pulse(0, 1, 1);
    wait_done("alt_done_latency", 40, c0, 15);
    check("alt_no_overrun", overrun, 0);
    rd_chk("alt_idx0", 0, 12);

    // Simultaneous rises: right drains before left; one done pulse.
    clear_pulse();
    load3(0, 1, 2, 10, 3, 4, 10, 5, 6, 10);
    load3(1, -1, 2, 11, -3, 4, 11, 2, 2, 11);
    c0 = cyc;
    pulse(1, 1, 1);
    repeat (4) tick();
    rd_chk("sim_right_first_idx10", 10, 44);
    rd_chk("sim_left_second_idx11", 11, -2);
    wait_done("sim_done_latency", 20, c0, 9);
    tick();
    check("sim_done_single", done, 0);
    rd_chk("sim_idx11_final", 11, -10);

    // Zero-padded tail entries must not touch a stale, invalidated entry.
    load3(0, 6, 7, 5, 0, 0, 5, 0, 0, 5);
    c0 = cyc;
    pulse(1, 0, 1);
    wait_done("tail_pre_done", 30, c0, -1);
    rd_chk("tail_pre_idx5", 5, 42);
    clear_pulse();
    load3(0, 2, 3, 4, 0, 7, 5, 4, 0, 5);
    c0 = cyc;
    pulse(1, 0, 1);
    wait_done("tail_done", 30, c0, -1);
    rd_chk("tail_idx5_invalid", 5, 0);
    rd_chk("tail_idx4", 4, 6);

    // Right re-rises while its slot still waits behind the left buffer.
    check("ovr_clear_before", overrun, 0);
    load3(1, 1, 1, 20, 1, 1, 20, 1, 1, 20);
    load3(0, 2, 3, 21, 2, 3, 21, 2, 3, 21);
    c0 = cyc;
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    tick();
    load3(0, 100, 100, 21, 100, 100, 21, 100, 100, 21);
    pulse(1, 0, 0);
    check("ovr_set", overrun, 1);
    pulse(0, 0, 1);
    wait_done("ovr_done", 30, c0, -1);
    rd_chk("ovr_first_buffer_kept", 21, 18);
    rd_chk("ovr_left_buffer", 20, 3);

    // Clear landing in the same cycle as a write: write wins with a zero base.
    load3(0, 5, 1, 30, 0, 0, 30, 0, 0, 30);
    c0 = cyc;
    pulse(1, 0, 1);
    wait_done("clrw_pre_done", 30, c0, -1);
    load3(0, 1, 1, 30, 0, 0, 30, 0, 0, 30);
    c0 = cyc;
    pulse(1, 0, 0);
    tick();
    clear_pulse();
    pulse(0, 0, 1);
    wait_done("clrw_done", 30, c0, -1);
    rd_chk("clrw_idx30_write_wins", 30, 1);
    rd_chk("clrw_idx20_cleared", 20, 0);

    // Accumulate, clear, accumulate again.
    load3(0, 10, 10, 3, 0, 0, 3, 0, 0, 3);
    c0 = cyc;
    pulse(1, 0, 1);
    wait_done("clr_pre_done", 30, c0, -1);
    rd_chk("clr_idx3_100", 3, 100);
    clear_pulse();
    load3(0, -2, 2, 3, 0, 0, 3, 0, 0, 3);
    c0 = cyc;
    pulse(1, 0, 1);
    wait_done("clr_post_done", 30, c0, -1);
    rd_chk("clr_idx3_minus4", 3, -4);
    check("ovr_sticky", overrun, 1);

    // Reset in the middle of issuing discards everything.
    load3(1, 7, 7, 50, 7, 7, 50, 7, 7, 50);
    pulse(0, 1, 0);
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_rd_data", rd_data, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    rd_chk("mid_rst_idx50", 50, 0);
    rd_chk("mid_rst_idx3", 3, 0);
    repeat (4) tick();
    check("mid_rst_idle", busy, 0);

    // Randomized buffers against the partial-sum model (state is fresh after reset).
    for (int i = 0; i < 128; i++) model[i] = '0;
    c0 = cyc;
    for (int b = 0; b < 20; b++) begin
      logic [2:0][15:0] w, ia;
      logic [2:0][20:0] a;
      for (int e = 0; e < 3; e++) begin
        w[e]  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 65535));
        ia[e] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 65535));
        a[e]  = 21'($urandom);
        ws = w[e]; ias = ia[e];
        idx = int'(a[e][6:0]);
        if (ws != 0 && ias != 0) begin
          p = longint'(ws) * longint'(ias);
          model[idx] = model[idx] + 40'(p);
        end
      end
      load(b[0], w, ia, a);
      pulse(!b[0], b[0], b == 19);
      repeat ($urandom_range(2, 5)) tick();
    end
    wait_done("rand_done", 60, c0, -1);
    check("rand_no_overrun", overrun, 0);
    for (int i = 0; i < 128; i++) rd_chk($sformatf("rand_idx%0d", i), i, model[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
